// File: rtl/vga_timing_gen_if.sv
// Video output bundle driven by vga_timing_gen: syncs, display enable,
// pixel coordinates, lookahead fetch request, strobes and frame count.
interface vga_timing_gen_if #(
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 9,
    parameter int unsigned FCNT_W = 16
);
    logic              hs;
    logic              vs;
    logic              disp_en;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              req;
    logic [XW-1:0]     req_x;
    logic [YW-1:0]     req_y;
    logic              line_start;
    logic              frame_start;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output hs, vs, disp_en, x, y, req, req_x, req_y,
               line_start, frame_start, busy, frame_cnt
    );

    modport slave (
        input  hs, vs, disp_en, x, y, req, req_x, req_y,
               line_start, frame_start, busy, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with frame-boundary run/stop gating and
// a lookahead fetch request that leads display enable by LOOKAHEAD cycles.
module vga_timing_gen #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter int unsigned HFP       = 40,
    parameter int unsigned HPULSE    = 48,
    parameter int unsigned HBP       = 40,
    parameter int unsigned VFP       = 13,
    parameter int unsigned VPULSE    = 3,
    parameter int unsigned VBP       = 29,
    parameter int unsigned HS_POL    = 0,
    parameter int unsigned VS_POL    = 0,
    parameter int unsigned LOOKAHEAD = 2,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic             run,
    vga_timing_gen_if.master vid
);
    localparam int unsigned HBLK      = HFP + HPULSE + HBP;
    localparam int unsigned HTOT      = HBLK + HDISP;
    localparam int unsigned HSYNC_END = HFP + HPULSE;
    localparam int unsigned VBLK      = VFP + VPULSE + VBP;
    localparam int unsigned VTOT      = VBLK + VDISP;
    localparam int unsigned VSYNC_END = VFP + VPULSE;
    localparam int unsigned HW        = $clog2(HTOT);
    localparam int unsigned VW        = $clog2(VTOT);
    localparam int unsigned XW        = $clog2(HDISP);
    localparam int unsigned YW        = $clog2(VDISP);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [HW-1:0] hcnt, rhcnt;
    logic [VW-1:0] vcnt, rvcnt;
    logic          h_last, v_last, rh_last, rv_last, frame_last;

    logic              hs_c, vs_c, de_c, req_c, ls_c, fs_c, busy_c, fcnt_inc_c;
    logic [XW-1:0]     x_c, rx_c;
    logic [YW-1:0]     y_c, ry_c;

    logic              hs_q, vs_q, de_q, req_q, ls_q, fs_q, busy_q, started_q;
    logic [XW-1:0]     x_q, rx_q;
    logic [YW-1:0]     y_q, ry_q;
    logic [FCNT_W-1:0] fcnt_q;

    assign h_last     = (hcnt == HW'(HTOT - 1));
    assign v_last     = (vcnt == VW'(VTOT - 1));
    assign rh_last    = (rhcnt == HW'(HTOT - 1));
    assign rv_last    = (rvcnt == VW'(VTOT - 1));
    assign frame_last = h_last && v_last;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Stop is only honoured on the last pixel, so a frame is never truncated.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = RUN;
            RUN:     if (frame_last && !run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters plus a second pair running LOOKAHEAD positions ahead.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcnt  <= '0;
            vcnt  <= '0;
            rhcnt <= HW'(LOOKAHEAD);
            rvcnt <= '0;
        end else if (state == RUN) begin
            hcnt  <= h_last ? '0 : hcnt + HW'(1);
            rhcnt <= rh_last ? '0 : rhcnt + HW'(1);
            if (h_last)  vcnt  <= v_last ? '0 : vcnt + VW'(1);
            if (rh_last) rvcnt <= rv_last ? '0 : rvcnt + VW'(1);
        end else begin
            hcnt  <= '0;
            vcnt  <= '0;
            rhcnt <= HW'(LOOKAHEAD);
            rvcnt <= '0;
        end
    end

    // The ahead pair only crosses into the next frame within its first
    // LOOKAHEAD <= HBLK pixels, which are blank, so a stopped frame never
    // issues a request for the frame that follows it.
    always_comb begin
        hs_c       = ~1'(HS_POL);
        vs_c       = ~1'(VS_POL);
        de_c       = 1'b0;
        x_c        = '0;
        y_c        = '0;
        req_c      = 1'b0;
        rx_c       = '0;
        ry_c       = '0;
        ls_c       = 1'b0;
        fs_c       = 1'b0;
        busy_c     = 1'b0;
        fcnt_inc_c = 1'b0;
        if (state == RUN) begin
            if (hcnt >= HW'(HFP) && hcnt < HW'(HSYNC_END)) hs_c = 1'(HS_POL);
            if (vcnt >= VW'(VFP) && vcnt < VW'(VSYNC_END)) vs_c = 1'(VS_POL);
            if (hcnt >= HW'(HBLK) && vcnt >= VW'(VBLK)) begin
                de_c = 1'b1;
                x_c  = XW'(hcnt - HW'(HBLK));
                y_c  = YW'(vcnt - VW'(VBLK));
            end
            if (rhcnt >= HW'(HBLK) && rvcnt >= VW'(VBLK)) begin
                req_c = 1'b1;
                rx_c  = XW'(rhcnt - HW'(HBLK));
                ry_c  = YW'(rvcnt - VW'(VBLK));
            end
            ls_c       = (hcnt == '0);
            fs_c       = ls_c && (vcnt == '0);
            busy_c     = 1'b1;
            fcnt_inc_c = fs_c && started_q;
        end
    end

    // Single register stage so every video output is aligned to the same count.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_q      <= ~1'(HS_POL);
            vs_q      <= ~1'(VS_POL);
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            req_q     <= 1'b0;
            rx_q      <= '0;
            ry_q      <= '0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            started_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            hs_q   <= hs_c;
            vs_q   <= vs_c;
            de_q   <= de_c;
            x_q    <= x_c;
            y_q    <= y_c;
            req_q  <= req_c;
            rx_q   <= rx_c;
            ry_q   <= ry_c;
            ls_q   <= ls_c;
            fs_q   <= fs_c;
            busy_q <= busy_c;
            if (state != RUN) started_q <= 1'b0;
            else if (fs_c)    started_q <= 1'b1;
            if (fcnt_inc_c) fcnt_q <= fcnt_q + FCNT_W'(1);
        end
    end

    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.disp_en     = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.req         = req_q;
    assign vid.req_x       = rx_q;
    assign vid.req_y       = ry_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
    assign vid.busy        = busy_q;
    assign vid.frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: 208x96 raster, one active-low/lookahead-2
// instance and one active-high/lookahead-0 instance.
module tb_vga_timing_gen;
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned FW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, rst_b, run_b;
    logic b_done = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    vga_timing_gen_if #(.XW(XW), .YW(YW), .FCNT_W(FW)) va ();
    vga_timing_gen_if #(.XW(XW), .YW(YW), .FCNT_W(FW)) vb ();

    vga_timing_gen #(
        .HDISP(160), .VDISP(90), .HFP(8), .HPULSE(16), .HBP(24),
        .VFP(1), .VPULSE(2), .VBP(3), .HS_POL(0), .VS_POL(0),
        .LOOKAHEAD(2), .FCNT_W(FW)
    ) dut_a (.pixel_clk(clk), .pixel_rst(rst), .run(run), .vid(va));

    vga_timing_gen #(
        .HDISP(160), .VDISP(90), .HFP(8), .HPULSE(16), .HBP(24),
        .VFP(1), .VPULSE(2), .VBP(3), .HS_POL(1), .VS_POL(0),
        .LOOKAHEAD(0), .FCNT_W(FW)
    ) dut_b (.pixel_clk(clk), .pixel_rst(rst_b), .run(run_b), .vid(vb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Measurements taken on the falling edge, away from the output update.
    int cyc = 0;
    int ls_last = -1, ls_period = 0, fs_last = -1, fs_period = 0, n_fs = 0, fc_at_fs = -1;
    int hs_off = 0, hs_len = 0, hs_run = 0, vs_off = 0, vs_len = 0, vs_run = 0;
    int de_run = 0, de_len = 0, x_err = 0, y_err = 0, act_lines = 0, lines_last = 0;
    int first_line = -1, first_y = -1, last_y = -1;
    int req_err = 0, req_cnt = 0, req_last = 0;
    int n_bf = 0, bf_off = 0, bf_lines = 0, bf_req = 0;
    int lsb_last = 0, hsb_off = 0, hsb_len = 0, hsb_run = 0, reqb_err = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0, prev_busy = 1'b0, first_seen = 1'b0;
    logic prev_hsb = 1'b0, rq1 = 1'b0, rq2 = 1'b0;
    logic [XW-1:0] rx1 = '0, rx2 = '0;
    logic [YW-1:0] ry1 = '0, ry2 = '0;

    always @(negedge clk) begin
        cyc++;
        if (va.disp_en) begin
            if (!prev_de) begin
                de_run = 0;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_line = (cyc - fs_last) / 208;
                    first_y    = int'(va.y);
                end
            end
            if (int'(va.x) != de_run) x_err++;
            if (int'(va.y) != (cyc - fs_last) / 208 - 6) y_err++;
            last_y = int'(va.y);
            de_run++;
        end else if (prev_de) begin
            de_len = de_run;
            act_lines++;
        end
        if (cyc > 2) begin
            if (rq2 != va.disp_en) req_err++;
            else if (va.disp_en && (rx2 != va.x || ry2 != va.y)) req_err++;
        end
        if (va.req) req_cnt++;
        rq2 = rq1; rx2 = rx1; ry2 = ry1;
        rq1 = va.req; rx1 = va.req_x; ry1 = va.req_y;
        if (prev_busy && !va.busy) begin
            n_bf++;
            bf_off   = cyc - fs_last;
            bf_lines = act_lines;
            bf_req   = req_cnt;
        end
        if (prev_hs && !va.hs) begin hs_off = cyc - ls_last; hs_run = 0; end
        if (!va.hs) hs_run++; else if (!prev_hs) hs_len = hs_run;
        if (prev_vs && !va.vs) begin vs_off = cyc - fs_last; vs_run = 0; end
        if (!va.vs) vs_run++; else if (!prev_vs) vs_len = vs_run;
        if (va.frame_start) begin
            if (fs_last >= 0) fs_period = cyc - fs_last;
            fs_last    = cyc;
            n_fs++;
            fc_at_fs   = int'(va.frame_cnt);
            req_last   = req_cnt;
            req_cnt    = 0;
            lines_last = act_lines;
            act_lines  = 0;
            first_seen = 1'b0;
        end
        if (va.line_start) begin
            if (ls_last >= 0) ls_period = cyc - ls_last;
            ls_last = cyc;
        end
        prev_hs = va.hs; prev_vs = va.vs; prev_de = va.disp_en; prev_busy = va.busy;
        // Second instance: req must track disp_en with zero lookahead.
        if (vb.req != vb.disp_en || vb.req_x != vb.x || vb.req_y != vb.y) reqb_err++;
        if (!prev_hsb && vb.hs) begin hsb_off = cyc - lsb_last; hsb_run = 0; end
        if (vb.hs) hsb_run++; else if (prev_hsb) hsb_len = hsb_run;
        if (vb.line_start) lsb_last = cyc;
        prev_hsb = vb.hs;
    end

    initial begin
        rst_b = 1'b1;
        run_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_rst_hs", 32'(vb.hs), 0);
        check("b_rst_vs", 32'(vb.vs), 1);
        rst_b = 1'b0;
        run_b = 1'b1;
        for (int i = 0; i < 3000 && !vb.disp_en; i++) @(negedge clk);
        check("b_wait_de", 32'(vb.disp_en), 1);
        repeat (20) @(negedge clk);
        #1;
        check("b_hs_off", 32'(hsb_off), 8);
        check("b_hs_len", 32'(hsb_len), 16);
        check("b_req_eq_de", 32'(reqb_err), 0);
        check("b_de_pre", 32'(vb.disp_en), 1);
        #1 rst_b = 1'b1;
        #1;
        check("b_async_hs", 32'(vb.hs), 0);
        check("b_async_vs", 32'(vb.vs), 1);
        check("b_async_de", 32'(vb.disp_en), 0);
        check("b_async_x", 32'(vb.x), 0);
        check("b_async_req", 32'(vb.req), 0);
        check("b_async_busy", 32'(vb.busy), 0);
        @(negedge clk);
        run_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        check("b_hold_idle", 32'(vb.busy), 0);
        run_b = 1'b1;
        @(negedge clk);
        check("b_restart_lat", 32'(vb.frame_start), 0);
        @(negedge clk);
        check("b_restart_fs", 32'(vb.frame_start), 1);
        check("b_restart_busy", 32'(vb.busy), 1);
        b_done = 1'b1;
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hs", 32'(va.hs), 1);
        check("rst_vs", 32'(va.vs), 1);
        check("rst_de", 32'(va.disp_en), 0);
        check("rst_busy", 32'(va.busy), 0);
        check("rst_fcnt", 32'(va.frame_cnt), 0);
        check("rst_req", 32'(va.req), 0);
        rst = 1'b0;
        run = 1'b1;

        for (int i = 0; i < 45000 && n_fs < 2; i++) @(posedge clk);
        check("wait_fs2", 32'(n_fs >= 2), 1);
        check("ls_period", 32'(ls_period), 208);
        check("hs_off", 32'(hs_off), 8);
        check("hs_len", 32'(hs_len), 16);
        check("de_len", 32'(de_len), 160);
        check("x_seq", 32'(x_err), 0);
        check("y_seq", 32'(y_err), 0);
        check("vs_off", 32'(vs_off), 208);
        check("vs_len", 32'(vs_len), 416);
        check("first_line", 32'(first_line), 6);
        check("first_y", 32'(first_y), 0);
        check("lines", 32'(lines_last), 90);
        check("fs_period", 32'(fs_period), 19968);
        check("req_count", 32'(req_last), 14400);
        check("req_lead", 32'(req_err), 0);
        check("fcnt_fs2", 32'(fc_at_fs), 1);

        for (int i = 0; i < 20000 && last_y != 40; i++) @(posedge clk);
        check("wait_y40", 32'(last_y), 40);
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 21000 && n_bf < 1; i++) @(posedge clk);
        check("wait_stop", 32'(n_bf), 1);
        check("stop_frame_len", 32'(bf_off), 19968);
        check("stop_lines", 32'(bf_lines), 90);
        check("stop_req_count", 32'(bf_req), 14400);
        check("stop_last_y", 32'(last_y), 89);
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(va.busy), 0);
        check("idle_hs", 32'(va.hs), 1);
        check("idle_vs", 32'(va.vs), 1);
        check("idle_de", 32'(va.disp_en), 0);
        check("idle_req", 32'(va.req), 0);
        check("idle_ls", 32'(va.line_start), 0);
        check("idle_fcnt", 32'(va.frame_cnt), 1);
        check("idle_no_fs", 32'(n_fs), 2);

        run = 1'b1;
        @(negedge clk);
        check("restart_lat", 32'(va.frame_start), 0);
        @(negedge clk);
        check("restart_fs", 32'(va.frame_start), 1);
        check("restart_busy", 32'(va.busy), 1);
        check("restart_fcnt", 32'(va.frame_cnt), 1);
        for (int i = 0; i < 21000 && n_fs < 4; i++) @(posedge clk);
        check("wait_fs4", 32'(n_fs), 4);
        check("fcnt_after", 32'(fc_at_fs), 2);
        check("fs_period2", 32'(fs_period), 19968);
        check("lines2", 32'(lines_last), 90);
        check("req_lead2", 32'(req_err), 0);
        check("b_req_eq_de_end", 32'(reqb_err), 0);

        for (int i = 0; i < 1000 && !b_done; i++) @(posedge clk);
        check("b_done", 32'(b_done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised video timing generator producing HS/VS/display-enable and pixel coordinates for any resolution, porch set and sync polarity.
- Sits between the pixel-clock domain and the video interface (video_if) driver. Feeds the frame-buffer read side through a pixel lookahead request, so a downstream FIFO/pipeline of known depth has data ready exactly when display starts.
- Adds run/stop gating at frame boundaries, plus frame and line strobes and a frame counter.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixel clocks)
- HPULSE, 48, horizontal sync width
- HBP, 40, horizontal back porch
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width
- VBP, 29, vertical back porch
- HS_POL, 0, active level of HS (0 = active-low)
- VS_POL, 0, active level of VS
- LOOKAHEAD, 2, cycles by which req leads disp_en; 0 <= LOOKAHEAD <= HFP+HPULSE+HBP
- FCNT_W, 16, frame counter width

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  asynchronous reset, active-high
- run  in  1  start/continue request
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- disp_en  out  1  high during active pixels
- x  out  $clog2(HDISP)  active pixel column, valid when disp_en=1
- y  out  $clog2(VDISP)  active line, valid when disp_en=1
- req  out  1  fetch request: disp_en will be 1 exactly LOOKAHEAD cycles later
- req_x  out  $clog2(HDISP)  column for req
- req_y  out  $clog2(VDISP)  line for req
- line_start  out  1  one-cycle pulse at hcnt=0 of every line
- frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0
- busy  out  1  generator running
- frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- HTOT = HFP+HPULSE+HBP+HDISP; VTOT = VFP+VPULSE+VBP+VDISP.
- Line layout by hcnt, 0..HTOT-1:
  - [0, HFP): front porch
  - [HFP, HFP+HPULSE): sync
  - then back porch
  - [HBLK=HFP+HPULSE+HBP, HTOT): display
- Frame layout uses vcnt with the same ordering; VBLK = VFP+VPULSE+VBP.
- States:
  - IDLE: counters held at 0; hs/vs inactive; disp_en, req, strobes all 0.
  - RUN: hcnt increments every cycle, wraps to 0 at HTOT-1; vcnt increments on hcnt wrap, wraps at VTOT-1.
  - IDLE -> RUN when run=1 is sampled. The first RUN cycle has hcnt=0, vcnt=0.
  - RUN -> IDLE only at the last pixel of a frame (hcnt=HTOT-1, vcnt=VTOT-1) if run=0 is sampled on that cycle. run dropping mid-frame never truncates a frame.
- Outputs are registered and reflect the counters with 1 cycle latency. All video outputs for counter state n appear together, so there is no skew between hs, vs, disp_en, x and y.
- disp_en=1 iff hcnt>=HBLK and vcnt>=VBLK. Then x=hcnt-HBLK and y=vcnt-VBLK; otherwise x=0, y=0.
- hs = HS_POL while hcnt is in the sync region, else ~HS_POL. vs follows the same rule on vcnt and changes only at hcnt=0.
- req: a second counter pair runs LOOKAHEAD positions ahead, wrapping across line and frame.
  - req/req_x/req_y at cycle t equal disp_en/x/y at cycle t+LOOKAHEAD.
  - Exception: no req is issued for a frame that will not be displayed, i.e. at the final frame after stop.
  - LOOKAHEAD=0: req is identical to disp_en.
- frame_cnt increments when frame_start is emitted for every frame after the first one since RUN entry; it is not cleared on stop.
- busy=1 in RUN, including the final frame after run drops.
- Reset, asserted at any time: IDLE, counters 0, hs=~HS_POL, vs=~VS_POL, all other outputs 0, frame_cnt=0.
- Reset mid-frame: after release, restart only on run=1.

Test Plan:
- Reset values: HDISP=160, VDISP=90, HFP=8, HPULSE=16, HBP=24, VFP=1, VPULSE=2, VBP=3, HS_POL=VS_POL=0, LOOKAHEAD=2 (HTOT=208, VTOT=96). Assert pixel_rst -> hs=1, vs=1, disp_en=0, busy=0, frame_cnt=0.
- Line timing: run=1 from reset release.
  - hs low for exactly 16 cycles starting 8 cycles after line_start.
  - disp_en high 160 consecutive cycles per displayed line, x running 0..159.
  - line_start period 208 cycles.
- Frame timing: vs low for 2 lines (416 cycles) starting 1 line after frame_start. disp_en first asserted on line 6 with y=0; 90 active lines; frame_start period 19968 cycles.
- Lookahead: req rises exactly 2 cycles before each disp_en rise, with req_x/req_y equal to the later x/y.
  - At line end, req for (0, y+1) precedes the next line's display.
  - Total req count per frame = 14400.
- Stop/start: deassert run at y=40 mid-frame -> frame completes (disp_en through y=89), then busy=0 and outputs idle. Reassert run -> frame_start on the first RUN cycle's output; frame_cnt unchanged across the stop.
- Polarity/reset: HS_POL=1, LOOKAHEAD=0 -> hs high during sync and req==disp_en every cycle. Assert pixel_rst mid-line -> outputs return to reset values without waiting for a clock edge.
